eeprom_req_ctrl: RTL and testbench

EEPROM_REQ_CTRL -- requirements
Module: eeprom_req_ctrl

---
 rtl/eeprom_pkg.sv | 34 +++
 rtl/eeprom_req_ctrl_if.sv | 26 ++
 rtl/eeprom_req_fifo.sv | 63 ++++++
 rtl/eeprom_req_ctrl.sv | 132 +++++++++++++
 tb/tb_eeprom_req_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeprom_pkg.sv
// Shared widths, request-entry layout and FSM encoding for the EEPROM request controller.
package eeprom_pkg;

    localparam int ADDR_W          = 11;
    localparam int DATA_W          = 8;
    localparam int ENTRY_W         = 1 + ADDR_W + DATA_W;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 1023;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_RESP
    } state_t;

    // Field order {wr, addr, wdata} is the FIFO storage layout.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_entry_t;

    function automatic req_entry_t pack_req(input logic              wr,
                                            input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] wdata);
        req_entry_t e;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        return e;
    endfunction

endpackage

// File: rtl/eeprom_req_ctrl_if.sv
// Host-side request/response bundle of the EEPROM request controller.
interface eeprom_req_ctrl_if;
    import eeprom_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_wr;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/eeprom_req_fifo.sv
// Count-based synchronous FIFO holding pending host requests (DEPTH must be a power of two).
module eeprom_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/eeprom_req_ctrl.sv
// Queues host byte read/write requests and sequences them one at a time onto a serial EEPROM engine.
// Optional ACK timeout is enabled by defining EEPROM_REQ_TIMEOUT_EN.
module eeprom_req_ctrl
    import eeprom_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    eeprom_req_ctrl_if.slave  host,
    output logic              WR,
    output logic              RD,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] DATA,
    input  logic              ACK
);

    state_t            state_q, state_d;
    req_entry_t        op_q, op_d;
    logic              rsp_wr_q, rsp_wr_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    req_entry_t        fifo_head;
    logic              timeout_hit;
    logic              drive_data;

    eeprom_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (host.req_valid),
        .wr_data (pack_req(host.req_wr, host.req_addr, host.req_wdata)),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef EEPROM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Counts WAIT_ACK cycles; the last count turns into a RESP on the following edge.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_WAIT_ACK && !ACK) to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end

    assign timeout_hit = (state_q == ST_WAIT_ACK) && (to_cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    op_d    = fifo_head;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (ACK) begin
                    rsp_wr_d    = op_q.wr;
                    rsp_rdata_d = op_q.wr ? '0 : DATA;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    rsp_wr_d    = op_q.wr;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The op register holds ADDR/wdata steady until the next pop, so the engine sees stable values.
    assign WR         = (state_q == ST_ISSUE) && op_q.wr;
    assign RD         = (state_q == ST_ISSUE) && !op_q.wr;
    assign ADDR       = op_q.addr;
    assign drive_data = op_q.wr && ((state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK));
    assign DATA       = drive_data ? op_q.wdata : 'z;

    assign host.req_ready = !fifo_full;
    assign host.rsp_valid = (state_q == ST_RESP);
    assign host.rsp_wr    = rsp_wr_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign host.rsp_err   = rsp_err_q;
    assign host.busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_eeprom_req_ctrl.sv
// Scoreboard bench for eeprom_req_ctrl: directed requests against a simple serial-engine model.
`timescale 1ns/1ps
module tb_eeprom_req_ctrl;
    import eeprom_pkg::*;

    typedef struct packed {
        logic       wr;
        logic [7:0] rdata;
        logic       err;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_s;
    logic        rd_s;
    logic [10:0] addr_s;
    tri1  [7:0]  data_bus;
    wire         ack;

    logic        eng_ack   = 1'b0;
    logic        stray_ack = 1'b0;
    logic        eng_drive = 1'b0;
    logic [7:0]  eng_data  = 8'h00;
    logic        eng_stall = 1'b0;
    int          ack_delay = 0;

    int          checks    = 0;
    int          passes    = 0;
    int          cyc       = 0;
    int          push_cyc  = 0;
    int          strobe_cyc = 0;
    int          rsp_cyc   = 0;
    int          rsp_count = 0;

    req_entry_t  exp_strobe_q[$];
    rsp_exp_t    exp_rsp_q[$];

    assign ack      = eng_ack | stray_ack;
    assign data_bus = eng_drive ? eng_data : 8'hzz;

    eeprom_req_ctrl_if host_if();

    eeprom_req_ctrl #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (1023)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .host  (host_if),
        .WR    (wr_s),
        .RD    (rd_s),
        .ADDR  (addr_s),
        .DATA  (data_bus),
        .ACK   (ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] engine_rd(input logic [10:0] a);
        case (a)
            11'h010: engine_rd = 8'hC3;
            11'h155: engine_rd = 8'h7E;
            default: engine_rd = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Pushes one request through the handshake and records what the DUT must do with it.
    task automatic applyStimulus(input logic wr, input logic [10:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] exp_rdata, input logic exp_err);
        int  waited;
        bit  done;
        rsp_exp_t r;
        waited = 0;
        done   = 1'b0;
        host_if.req_valid = 1'b1;
        host_if.req_wr    = wr;
        host_if.req_addr  = addr;
        host_if.req_wdata = wdata;
        while (!done && waited < 2000) begin
            @(negedge clk);
            if (host_if.req_ready) begin
                done     = 1'b1;
                push_cyc = cyc;
                exp_strobe_q.push_back(pack_req(wr, addr, wdata));
                r.wr    = wr;
                r.rdata = exp_rdata;
                r.err   = exp_err;
                exp_rsp_q.push_back(r);
            end
            @(posedge clk);
            #1;
            waited++;
        end
        host_if.req_valid = 1'b0;
        checkOutput("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (!host_if.busy && exp_rsp_q.size() == 0) ok = 1'b1;
        end
        checkOutput("idle_reached", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Engine model: acks ack_delay cycles after a strobe unless stalled; drives read data with ACK.
    initial begin : engine
        bit          pending;
        bit          is_rd;
        logic [10:0] p_addr;
        int          cnt;
        pending = 1'b0;
        is_rd   = 1'b0;
        p_addr  = '0;
        cnt     = 0;
        forever begin
            @(posedge clk);
            #1;
            eng_ack   = 1'b0;
            eng_drive = 1'b0;
            if (rst || host_if.rsp_valid) begin
                pending = 1'b0;
            end else if (wr_s || rd_s) begin
                pending = 1'b1;
                is_rd   = rd_s;
                p_addr  = addr_s;
                cnt     = ack_delay;
            end else if (pending && !eng_stall) begin
                if (cnt == 0) begin
                    eng_ack = 1'b1;
                    pending = 1'b0;
                    if (is_rd) begin
                        eng_drive = 1'b1;
                        eng_data  = engine_rd(p_addr);
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT strobes the engine or presents a response.
    initial begin : monitor
        bit         prev_strobe;
        bit         op_active;
        req_entry_t cur;
        req_entry_t e;
        rsp_exp_t   r;
        prev_strobe = 1'b0;
        op_active   = 1'b0;
        cur         = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_strobe = 1'b0;
                op_active   = 1'b0;
            end else begin
                if (prev_strobe) checkOutput("strobe_width", 32'({wr_s, rd_s}), 32'd0);
                if (wr_s || rd_s) begin
                    strobe_cyc = cyc;
                    checkOutput("strobe_exclusive", 32'(wr_s & rd_s), 32'd0);
                    if (exp_strobe_q.size() == 0) begin
                        checkOutput("unexpected_strobe", 32'({wr_s, rd_s}), 32'd0);
                    end else begin
                        e = exp_strobe_q.pop_front();
                        checkOutput("strobe_type", 32'(wr_s), 32'(e.wr));
                        checkOutput("strobe_addr", 32'(addr_s), 32'(e.addr));
                        if (e.wr) checkOutput("strobe_data", 32'(data_bus), 32'(e.wdata));
                        cur       = e;
                        op_active = 1'b1;
                    end
                end
                if (op_active && ack) begin
                    checkOutput("hold_addr", 32'(addr_s), 32'(cur.addr));
                    if (cur.wr) checkOutput("hold_data", 32'(data_bus), 32'(cur.wdata));
                end
                if (host_if.rsp_valid) begin
                    rsp_count++;
                    rsp_cyc   = cyc;
                    op_active = 1'b0;
                    if (exp_rsp_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'(host_if.rsp_valid), 32'd0);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        checkOutput("rsp_wr", 32'(host_if.rsp_wr), 32'(r.wr));
                        checkOutput("rsp_rdata", 32'(host_if.rsp_rdata), 32'(r.rdata));
                        checkOutput("rsp_err", 32'(host_if.rsp_err), 32'(r.err));
                    end
                end
                prev_strobe = wr_s || rd_s;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        host_if.req_valid = 1'b0;
        host_if.req_wr    = 1'b0;
        host_if.req_addr  = '0;
        host_if.req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr", 32'(wr_s), 32'd0);
        checkOutput("rst_rd", 32'(rd_s), 32'd0);
        checkOutput("rst_addr", 32'(addr_s), 32'd0);
        checkOutput("rst_data_z", 32'(data_bus), 32'hFF);
        checkOutput("rst_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
        checkOutput("rst_rsp_fields", 32'({host_if.rsp_wr, host_if.rsp_rdata, host_if.rsp_err}), 32'd0);
        checkOutput("rst_busy", 32'(host_if.busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(host_if.req_ready), 32'd1);

        $display("[TB] write 0x3A5 <- 0x5C");
        ack_delay = 3;
        applyStimulus(1'b1, 11'h3A5, 8'h5C, 8'h00, 1'b0);
        wait_idle(100);
        checkOutput("latency_wr", 32'(strobe_cyc - push_cyc), 32'd2);

        $display("[TB] read 0x010");
        ack_delay = 1;
        applyStimulus(1'b0, 11'h010, 8'hEE, 8'hC3, 1'b0);
        wait_idle(100);
        checkOutput("latency_rd", 32'(strobe_cyc - push_cyc), 32'd2);

        $display("[TB] stray ACK while idle");
        n = rsp_count;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("stray_rsp_count", 32'(rsp_count), 32'(n));
        checkOutput("stray_busy", 32'(host_if.busy), 32'd0);

        $display("[TB] fill FIFO with engine stalled");
        eng_stall = 1'b1;
        ack_delay = 0;
        applyStimulus(1'b1, 11'h100, 8'h11, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(1'b0, 11'h155, 8'h00, 8'h7E, 1'b0);
        applyStimulus(1'b1, 11'h7FF, 8'hA0, 8'h00, 1'b0);
        applyStimulus(1'b0, 11'h000, 8'h00, 8'h5A, 1'b0);
        applyStimulus(1'b1, 11'h2AA, 8'h33, 8'h00, 1'b0);
        checkOutput("ready_low_full", 32'(host_if.req_ready), 32'd0);
        checkOutput("busy_full", 32'(host_if.busy), 32'd1);
        fork
            applyStimulus(1'b0, 11'h0F0, 8'h00, 8'hAA, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                eng_stall = 1'b0;
            end
        join
        wait_idle(300);

        $display("[TB] reset during WAIT_ACK");
        eng_stall = 1'b1;
        applyStimulus(1'b0, 11'h123, 8'h00, 8'h79, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        n = rsp_count;
        rst = 1'b1;
        #1;
        checkOutput("arst_wr", 32'(wr_s), 32'd0);
        checkOutput("arst_rd", 32'(rd_s), 32'd0);
        checkOutput("arst_addr", 32'(addr_s), 32'd0);
        checkOutput("arst_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
        checkOutput("arst_busy", 32'(host_if.busy), 32'd0);
        exp_rsp_q.delete();
        exp_strobe_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        eng_stall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("arst_no_rsp", 32'(rsp_count), 32'(n));
        checkOutput("arst_ready", 32'(host_if.req_ready), 32'd1);
        checkOutput("arst_fifo_empty", 32'(host_if.busy), 32'd0);

`ifdef EEPROM_REQ_TIMEOUT_EN
        $display("[TB] ACK timeout");
        eng_stall = 1'b1;
        applyStimulus(1'b1, 11'h055, 8'h99, 8'h00, 1'b1);
        wait_idle(1200);
        checkOutput("timeout_cycles", 32'(rsp_cyc - strobe_cyc - 1), 32'd1023);
        eng_stall = 1'b0;
        ack_delay = 1;
        applyStimulus(1'b0, 11'h010, 8'h00, 8'hC3, 1'b0);
        wait_idle(100);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
